spi_prog_slave: RTL and testbench

SPI target that receives the byte-level flash-programming protocol (opcode 0x01 + 4 address bytes, opcode 0x02 + 4 data bytes, MSB first) and turns each completed data word into a single 32-bit write transaction. It sits behind the SCLK/CS/MOSI/MISO pads of `mpw_top`. It feeds the instruction-memory and PIM-buffer write ports while the core is held in reset. Oversampling runs entirely in the `clk` domain, and SCLK is treated as data.

---
 rtl/spi_prog_pkg.sv | 19 +
 rtl/spi_byte_rx.sv | 95 +++++++++
 rtl/spi_prog_slave.sv | 152 +++++++++++++++
 tb/tb_spi_prog_slave.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_prog_pkg.sv
// Shared definitions for the SPI programming target.
//   OP_ADDR / OP_DATA : command opcodes that open an address or data frame
//   CNT_W / LAST_BYTE : width and terminal value of the payload byte counter
//   state_t           : command FSM state encoding
package spi_prog_pkg;

    localparam logic [7:0] OP_ADDR = 8'h01;
    localparam logic [7:0] OP_DATA = 8'h02;

    localparam int               CNT_W     = 2;
    localparam logic [CNT_W-1:0] LAST_BYTE = 2'd3;

    typedef enum logic [1:0] {
        ST_CMD  = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver, oversampled in the i_clk domain.
//   i_clk, i_reset       : system clock, async active-high reset
//   i_sclk, i_cs_n, i_mosi : raw SPI pad inputs (synchronized here)
//   o_miso               : echo of the previously received byte, MSB first
//   o_busy               : synchronized chip select is asserted
//   o_byte_valid/o_byte  : one-cycle strobe with each completed byte
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_busy,
    output logic       o_byte_valid,
    output logic [7:0] o_byte
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_rx_sh;
    logic [7:0]             r_byte;
    logic                   r_byte_valid;
    logic [7:0]             r_tx;
    logic                   r_miso;

    logic w_sclk;
    logic w_mosi;
    logic w_active;
    logic w_rise;
    logic w_fall;

    assign w_sclk   = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
    assign w_active = ~r_cs_sync[SYNC_STAGES-1];
    // Edges only count while selected so stray SCLK activity is harmless.
    assign w_rise   = w_active & w_sclk & ~r_sclk_d;
    assign w_fall   = w_active & ~w_sclk & r_sclk_d;

    // The CS chain resets to the deselected level so busy starts low.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_d    <= w_sclk;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bit_cnt    <= 3'd0;
            r_rx_sh      <= 7'd0;
            r_byte       <= 8'd0;
            r_byte_valid <= 1'b0;
            r_tx         <= 8'd0;
            r_miso       <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            if (!w_active) begin
                r_bit_cnt <= 3'd0;
            end else if (w_rise) begin
                r_rx_sh   <= {r_rx_sh[5:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte       <= {r_rx_sh, w_mosi};
                    r_byte_valid <= 1'b1;
                    // The finished byte becomes the reply for the next one;
                    // its MSB goes out on the falling edge that closes this byte.
                    r_tx         <= {r_rx_sh, w_mosi};
                end
            end
            if (w_fall) begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
            end
        end
    end

    assign o_miso       = r_miso;
    assign o_busy       = w_active;
    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_byte;

endmodule

// File: rtl/spi_prog_slave.sv
// SPI flash-programming target: decodes 0x01+addr[4] / 0x02+data[4] frames
// and issues one 32-bit valid/ready write per completed data word.
//   clk, reset              : system clock, async active-high reset
//   sclk, cs_n, mosi, miso  : SPI mode-0 pads
//   wr_valid/wr_ready       : write handshake, wr_addr/wr_data held while valid
//   overflow, clr_overflow  : sticky dropped-word flag and its sync clear
//   busy                    : chip select currently asserted
module spi_prog_slave
    import spi_prog_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ADDR_INCR   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        overflow,
    input  logic        clr_overflow,
    output logic        busy
);

    logic       w_byte_valid;
    logic [7:0] w_byte;

    spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_sclk       (sclk),
        .i_cs_n       (cs_n),
        .i_mosi       (mosi),
        .o_miso       (miso),
        .o_busy       (busy),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte)
    );

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_addr_done;
    logic             w_data_done;
    logic [23:0]      r_addr_sh;
    logic [23:0]      r_data_sh;
    logic [31:0]      r_addr_reg;
    logic             r_wr_valid;
    logic [31:0]      r_wr_addr;
    logic [31:0]      r_wr_data;
    logic             r_overflow;
    logic             w_accept;

    assign w_accept = r_wr_valid & wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CMD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_done = 1'b0;
        w_data_done = 1'b0;
        if (w_byte_valid) begin
            case (r_state)
                ST_CMD: begin
                    w_cnt_nxt = '0;
                    if (w_byte == OP_ADDR)      w_state_nxt = ST_ADDR;
                    else if (w_byte == OP_DATA) w_state_nxt = ST_DATA;
                end
                ST_ADDR: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == LAST_BYTE) begin
                        w_addr_done = 1'b1;
                        w_state_nxt = ST_CMD;
                    end
                end
                ST_DATA: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == LAST_BYTE) begin
                        w_data_done = 1'b1;
                        w_state_nxt = ST_CMD;
                    end
                end
                default: w_state_nxt = ST_CMD;
            endcase
        end
    end

    // Only the three leading bytes are kept; the fourth arrives on w_byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_sh <= 24'd0;
            r_data_sh <= 24'd0;
        end else if (w_byte_valid) begin
            if (r_state == ST_ADDR) r_addr_sh <= {r_addr_sh[15:0], w_byte};
            if (r_state == ST_DATA) r_data_sh <= {r_data_sh[15:0], w_byte};
        end
    end

    // A freshly loaded address takes priority over the post-accept increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_reg <= 32'd0;
        end else if (w_addr_done) begin
            r_addr_reg <= {r_addr_sh, w_byte};
        end else if (w_accept) begin
            r_addr_reg <= r_addr_reg + ADDR_INCR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 32'd0;
            r_wr_data  <= 32'd0;
            r_overflow <= 1'b0;
        end else begin
            if (clr_overflow) r_overflow <= 1'b0;
            if (w_data_done && (!r_wr_valid || wr_ready)) begin
                // When the slot frees this same cycle the new word already
                // belongs to the incremented address.
                r_wr_valid <= 1'b1;
                r_wr_addr  <= w_accept ? (r_addr_reg + ADDR_INCR) : r_addr_reg;
                r_wr_data  <= {r_data_sh, w_byte};
            end else begin
                if (w_data_done) r_overflow <= 1'b1;
                if (w_accept)    r_wr_valid <= 1'b0;
            end
        end
    end

    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_spi_prog_slave.sv
// Directed plus randomized bench for spi_prog_slave with a frame-level model.
module tb_spi_prog_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        overflow;
    logic        clr_overflow;
    logic        busy;

    always #5 clk = ~clk;

    spi_prog_slave #(
        .SYNC_STAGES (2),
        .ADDR_INCR   (32'd4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .busy         (busy)
    );

    int          tests = 0;
    int          fails = 0;
    logic [63:0] cap_q[$];
    logic [31:0] m_addr;
    logic [7:0]  m_prev;
    bit          m_prev_ok;
    logic [7:0]  rx_echo;

    // Every accepted write, as {addr, data}.
    always @(negedge clk) begin
        if (!reset && wr_valid && wr_ready) cap_q.push_back({wr_addr, wr_data});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sends nbits of b MSB first inside one CS window; records miso at each rise.
    task automatic send_bits(input logic [7:0] b, input int nbits);
        cs_n = 1'b0;
        tick(4);
        check("busy_on", busy, 1'b1);
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            tick(6);
            rx_echo[7-i] = miso;
            sclk = 1'b1;
            tick(6);
            sclk = 1'b0;
        end
        tick(6);
        cs_n = 1'b1;
        tick(6);
        check("busy_off", busy, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
        if (m_prev_ok) check("miso_echo", rx_echo, m_prev);
        m_prev    = b;
        m_prev_ok = 1'b1;
    endtask

    task automatic frame_addr(input logic [31:0] a);
        send_byte(8'h01);
        for (int k = 0; k < 4; k++) send_byte(a[31-8*k -: 8]);
        m_addr = a;
    endtask

    task automatic send_data_frame(input logic [31:0] d);
        send_byte(8'h02);
        for (int k = 0; k < 4; k++) send_byte(d[31-8*k -: 8]);
    endtask

    // Data frame with wr_ready high: exactly one write at the model address.
    task automatic frame_data(input logic [31:0] d, input string tag);
        int n0;
        n0 = cap_q.size();
        send_data_frame(d);
        tick(4);
        check({tag, "_count"}, cap_q.size(), n0 + 1);
        if (cap_q.size() > n0) check({tag, "_write"}, cap_q[cap_q.size()-1], {m_addr, d});
        check({tag, "_idle"}, wr_valid, 1'b0);
        m_addr = m_addr + 32'd4;
    endtask

    initial begin
        int          n0;
        int          sel;
        logic [31:0] w1;
        logic [31:0] w2;

        reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        wr_ready = 1'b1; clr_overflow = 1'b0;
        tick(3);
        check("rst_miso", miso, 1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_addr", wr_addr, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick(2);
        m_addr = 32'd0; m_prev = 8'h00; m_prev_ok = 1'b1;

        // Addressed write, then the auto-incremented address.
        frame_addr(32'h1000_0000);
        frame_data(32'hDEAD_BEEF, "aw");
        check("aw_model_addr", m_addr, 32'h1000_0004);
        frame_data(32'h0BAD_F00D, "aw_next");

        // Burst of three words.
        frame_addr(32'h2000_0000);
        frame_data(32'h1122_3344, "burst0");
        frame_data(32'h5566_7788, "burst1");
        frame_data(32'h99AA_BBCC, "burst2");
        check("burst_end_addr", m_addr, 32'h2000_000C);

        // Backpressure: first word held, second dropped, overflow sticky.
        wr_ready = 1'b0;
        n0 = cap_q.size();
        w1 = $urandom; w2 = $urandom;
        send_data_frame(w1);
        check("bp_valid", wr_valid, 1'b1);
        check("bp_addr", wr_addr, m_addr);
        check("bp_data", wr_data, w1);
        check("bp_no_ovf", overflow, 1'b0);
        send_data_frame(w2);
        check("bp_ovf", overflow, 1'b1);
        check("bp_hold_valid", wr_valid, 1'b1);
        check("bp_hold_addr", wr_addr, m_addr);
        check("bp_hold_data", wr_data, w1);
        wr_ready = 1'b1;
        tick(4);
        check("bp_count", cap_q.size(), n0 + 1);
        if (cap_q.size() > n0) check("bp_write", cap_q[cap_q.size()-1], {m_addr, w1});
        check("bp_released", wr_valid, 1'b0);
        check("bp_ovf_sticky", overflow, 1'b1);
        m_addr = m_addr + 32'd4;
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        tick(1);
        check("bp_ovf_clr", overflow, 1'b0);
        frame_data(32'hCAFE_0001, "bp_after");

        // Abort after 5 bits, unknown opcode, then a data word.
        send_bits(8'h02, 5);
        m_prev_ok = 1'b0;
        send_byte(8'h7F);
        frame_data(32'h0000_002A, "abort");

        // MISO echo.
        send_byte(8'hA5);
        send_byte(8'h3C);
        check("echo_a5", rx_echo, 8'hA5);

        // Randomized frames against the frame-level model.
        for (int it = 0; it < 10; it++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0)      frame_addr($urandom);
            else if (sel == 1) frame_data($urandom, "rand");
            else               send_byte(8'($urandom_range(3, 255)));
        end

        // Reset in the middle of an address frame with a write pending.
        wr_ready = 1'b0;
        send_data_frame($urandom);
        check("mid_pending", wr_valid, 1'b1);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        #2;
        check("mid_rst_miso", miso, 1'b0);
        check("mid_rst_valid", wr_valid, 1'b0);
        check("mid_rst_addr", wr_addr, 32'd0);
        check("mid_rst_data", wr_data, 32'd0);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        tick(2);
        reset = 1'b0;
        wr_ready = 1'b1;
        m_addr = 32'd0; m_prev = 8'h00; m_prev_ok = 1'b1;
        tick(2);
        frame_data($urandom, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
